// File: rtl/pipe_ctrl_sched.sv
// Pipeline sequencer: merges stage stall requests, runs the exception flush/redirect + drain
// sequence and a stall watchdog. Define PIPE_STALL_PERF_EN to enable the stall_cycles counter.
module pipe_ctrl_sched #(
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned WDT_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CNT_W  = 32;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [CNT_W-1:0]    wdt_q;

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: an exception in RUN starts a HOLD_CYCLES-long drain
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (excepttype != '0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are combinational so stage registers react on the same edge
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst && state_q == RUN) begin
            if (excepttype != '0) begin
                flush = 1'b1;
                if (excepttype == EXC_INT) begin
                    new_pc = INT_VECTOR;
                end else if (excepttype == EXC_ERET) begin
                    new_pc = cp0_epc;
                end else begin
                    new_pc = EXC_VECTOR;
                end
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id || stallreq_if) begin
                stall = 6'b000111;
            end
        end
    end

    // Watchdog on consecutive pc stalls; the flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q         <= '0;
            stall_timeout <= 1'b0;
        end else if (flush || !stall[0]) begin
            wdt_q <= '0;
        end else begin
            if (wdt_q < CNT_W'(WDT_LIMIT)) begin
                wdt_q <= wdt_q + CNT_W'(1);
            end
            if (wdt_q >= CNT_W'(WDT_LIMIT - 1)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_STALL_PERF_EN
    // Saturating stalled-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[0] && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
